// File: rtl/counter_seq_ctrl.sv
// Segment sequencer driving an up/down counter's en/ud from a queued list of {dir, hold, len}.
// Latency: first segment drives on the edge after start; segments chain with no gap; host push backpressured by seg_ready.

// Generic synchronous FIFO with flush; head is read combinationally.
// Latency: pushed data visible at head the cycle after the push edge.
// Backpressure: caller must gate push with level<DEPTH and pop with level>0.
module seq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdat,
  output logic [W-1:0]             rdat,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: level/pointers define which entries are valid.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= wdat;
  end

  assign rdat = mem[rd_ptr];
endmodule

module counter_seq_ctrl #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     seg_valid,
  output logic                     seg_ready,
  input  logic                     seg_dir,
  input  logic                     seg_hold,
  input  logic [LEN_W-1:0]         seg_len,
  input  logic                     start,
  input  logic                     abort,
  output logic                     cnt_en,
  output logic                     cnt_ud,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int SW = LEN_W + 2;
  localparam int RW = LEN_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [RW-1:0]   remaining, rem_nxt;
  logic            en_nxt, ud_nxt, busy_nxt, done_nxt;
  logic            push, pop, fifo_empty;
  logic [SW-1:0]   head_dat;
  logic            head_dir, head_hold;
  logic [LEN_W-1:0] head_len;
  logic [RW-1:0]   head_rem;

  assign seg_ready  = (fifo_level < LW'(DEPTH));
  assign push       = seg_valid && seg_ready && !abort;
  assign fifo_empty = (fifo_level == '0);

  seq_fifo #(.W(SW), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (abort),
    .push  (push),
    .pop   (pop),
    .wdat  ({seg_dir, seg_hold, seg_len}),
    .rdat  (head_dat),
    .level (fifo_level)
  );

  assign {head_dir, head_hold, head_len} = head_dat;
  // len=0 stands for the full 2^LEN_W cycle count.
  assign head_rem = (head_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, head_len};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
      cnt_en    <= 1'b0;
      cnt_ud    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= rem_nxt;
      cnt_en    <= en_nxt;
      cnt_ud    <= ud_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = remaining;
    en_nxt    = cnt_en;
    ud_nxt    = cnt_ud;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    pop       = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      rem_nxt   = '0;
      en_nxt    = 1'b0;
      ud_nxt    = 1'b0;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          en_nxt   = 1'b0;
          busy_nxt = 1'b0;
          if (start && !fifo_empty) begin
            pop       = 1'b1;
            state_nxt = RUN;
            rem_nxt   = head_rem;
            en_nxt    = ~head_hold;
            ud_nxt    = head_dir;
            busy_nxt  = 1'b1;
          end
        end
        RUN: begin
          rem_nxt = remaining - RW'(1);
          if (remaining == RW'(1)) begin
            if (!fifo_empty) begin
              // Chain the next segment on the same edge so there is no idle gap.
              pop      = 1'b1;
              rem_nxt  = head_rem;
              en_nxt   = ~head_hold;
              ud_nxt   = head_dir;
            end else begin
              state_nxt = DONE;
              rem_nxt   = '0;
              en_nxt    = 1'b0;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end
          end
        end
        DONE: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with DEPTH=4, LEN_W=8; expectations are hand-computed traces.
module tb_counter_seq_ctrl;
  logic       clock = 1'b0;
  logic       reset;
  logic       seg_valid, seg_ready, seg_dir, seg_hold;
  logic [7:0] seg_len;
  logic       start, abort;
  logic       cnt_en, cnt_ud, busy, done;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;

  counter_seq_ctrl #(.DEPTH(4), .LEN_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .seg_valid  (seg_valid),
    .seg_ready  (seg_ready),
    .seg_dir    (seg_dir),
    .seg_hold   (seg_hold),
    .seg_len    (seg_len),
    .start      (start),
    .abort      (abort),
    .cnt_en     (cnt_en),
    .cnt_ud     (cnt_ud),
    .busy       (busy),
    .done       (done),
    .fifo_level (fifo_level)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic d, input logic h, input logic [7:0] l);
    seg_valid = 1'b1; seg_dir = d; seg_hold = h; seg_len = l;
    tick();
    seg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; seg_valid = 0; seg_dir = 0; seg_hold = 0; seg_len = 0;
    start = 0; abort = 0;
    repeat (2) @(posedge clock);
    #3;
    checks++;
    if ({cnt_en, cnt_ud, busy, done} !== 4'b0000 || fifo_level !== 3'd0 || seg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: en/ud/busy/done=%b level=%0d rdy=%b, want 0000 0 1",
               {cnt_en, cnt_ud, busy, done}, fifo_level, seg_ready);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    push(1, 0, 8'd5);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({cnt_en, cnt_ud, busy, done} !== 4'b1110) begin
        errors++;
        $display("FAIL single_run[%0d]: en/ud/busy/done=%b want 1110", i, {cnt_en, cnt_ud, busy, done});
      end
      tick();
    end
    checks++;
    if ({cnt_en, busy, done} !== 3'b001) begin
      errors++;
      $display("FAIL single_done: en/busy/done=%b want 001", {cnt_en, busy, done});
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_after: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] en_tr = 9'b111100111;
    logic [8:0] ud_tr = 9'b111111000;
    push(0, 0, 8'd3);
    push(1, 1, 8'd2);
    push(1, 0, 8'd4);
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (cnt_en !== en_tr[i] || cnt_ud !== ud_tr[i] || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_trace[%0d]: en=%b ud=%b busy=%b done=%b want en=%b ud=%b busy=1 done=0",
                 i, cnt_en, cnt_ud, busy, done, en_tr[i], ud_tr[i]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: done=%b busy=%b want 1 0", done, busy);
    end
    tick();
  endtask

  task automatic test_full();
    int n = 0;
    for (int i = 0; i < 4; i++) push(0, 0, 8'd3);
    checks++;
    if (fifo_level !== 3'd4 || seg_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_level: level=%0d rdy=%b want 4 0", fifo_level, seg_ready);
    end
    push(1, 0, 8'd7);
    checks++;
    if (fifo_level !== 3'd4) begin
      errors++;
      $display("FAIL full_drop: level=%0d want 4", fifo_level);
    end
    pulse_start();
    checks++;
    if (fifo_level !== 3'd3 || seg_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_pop: level=%0d rdy=%b want 3 1", fifo_level, seg_ready);
    end
    for (int c = 0; c < 100 && done !== 1'b1; c++) begin
      if (cnt_en === 1'b1) n++;
      tick();
    end
    checks++;
    if (done !== 1'b1 || n != 12) begin
      errors++;
      $display("FAIL full_run: en_cycles=%0d done=%b want 12 1", n, done);
    end
    tick();
  endtask

  task automatic test_len0();
    int n = 0;
    push(0, 0, 8'd0);
    pulse_start();
    for (int c = 0; c < 400 && done !== 1'b1; c++) begin
      if (cnt_en === 1'b1 && cnt_ud === 1'b0) n++;
      tick();
    end
    checks++;
    if (done !== 1'b1 || n != 256) begin
      errors++;
      $display("FAIL len0_run: en_cycles=%0d done=%b want 256 1", n, done);
    end
    tick();
  endtask

  task automatic test_late_push();
    logic [5:0] ud_tr = 6'b110000;
    push(0, 0, 8'd4);
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (cnt_en !== 1'b1 || cnt_ud !== ud_tr[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL late_trace[%0d]: en=%b ud=%b busy=%b want 1 %b 1", i, cnt_en, cnt_ud, busy, ud_tr[i]);
      end
      if (i == 1) begin
        seg_valid = 1'b1; seg_dir = 1; seg_hold = 0; seg_len = 8'd2;
      end
      if (i == 2) seg_valid = 1'b0;
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL late_done: done=%b want 1", done);
    end
    tick();
    // Push lands on the same cycle as the last-cycle decision: must stay queued.
    push(0, 0, 8'd2);
    pulse_start();
    tick();
    seg_valid = 1'b1; seg_dir = 1; seg_hold = 1; seg_len = 8'd3;
    tick();
    seg_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd1) begin
      errors++;
      $display("FAIL late_edge: done=%b busy=%b level=%0d want 1 0 1", done, busy, fifo_level);
    end
    tick();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({cnt_en, cnt_ud, busy} !== 3'b011) begin
        errors++;
        $display("FAIL late_queued[%0d]: en/ud/busy=%b want 011", i, {cnt_en, cnt_ud, busy});
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL late_queued_done: done=%b level=%0d want 1 0", done, fifo_level);
    end
    tick();
  endtask

  task automatic test_abort();
    int dn = 0;
    push(1, 0, 8'd10);
    push(0, 0, 8'd3);
    push(0, 1, 8'd3);
    pulse_start();
    tick();
    tick();
    // Third run cycle: abort, with a coinciding push that must be dropped.
    abort = 1'b1; seg_valid = 1'b1; seg_dir = 1; seg_hold = 0; seg_len = 8'd4;
    tick();
    abort = 1'b0; seg_valid = 1'b0;
    checks++;
    if ({cnt_en, cnt_ud, busy, done} !== 4'b0000 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL abort_state: en/ud/busy/done=%b level=%0d want 0000 0",
               {cnt_en, cnt_ud, busy, done}, fifo_level);
    end
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1) dn++;
      tick();
    end
    pulse_start();
    for (int c = 0; c < 4; c++) begin
      if (done === 1'b1 || busy === 1'b1 || cnt_en === 1'b1) dn++;
      tick();
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL abort_quiet: activity_cycles=%0d want 0", dn);
    end
  endtask

  task automatic test_reset_mid_run();
    push(1, 0, 8'd10);
    push(0, 0, 8'd5);
    pulse_start();
    tick();
    checks++;
    if (cnt_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: en=%b want 1", cnt_en);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({cnt_en, cnt_ud, busy, done} !== 4'b0000 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL rst_async: en/ud/busy/done=%b level=%0d want 0000 0",
               {cnt_en, cnt_ud, busy, done}, fifo_level);
    end
    tick();
    reset = 1'b1;
    tick();
    pulse_start();
    tick();
    checks++;
    if (busy !== 1'b0 || cnt_en !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL rst_start_ignored: busy=%b en=%b level=%0d want 0 0 0", busy, cnt_en, fifo_level);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_len0();
    test_late_push();
    test_abort();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Sequencer for the example up/down counter. It sits between a host and the counter's enable and up/down inputs. The host pushes a queue of segments (direction, hold, length), then issues start. The block drives the counter's en/ud for exactly the programmed cycle counts, back-to-back, and pulses done when the queue drains.

Parameters:
DEPTH, 4, segment FIFO entries (power of 2, >=2)
LEN_W, 8, segment length width; len=0 encodes 2^LEN_W cycles

Ports:
clock  input  1  system clock, all state on posedge
reset  input  1  asynchronous active-low reset
seg_valid  input  1  host offers a segment
seg_ready  output  1  FIFO can accept; push when seg_valid && seg_ready
seg_dir  input  1  value driven on cnt_ud during the segment
seg_hold  input  1  1 = pause segment (cnt_en=0 for its length)
seg_len  input  LEN_W  segment duration in cycles
start  input  1  begin executing the queue (one-cycle pulse)
abort  input  1  flush queue, stop immediately
cnt_en  output  1  counter enable
cnt_ud  output  1  counter up/down select
busy  output  1  high while in RUN
done  output  1  one-cycle pulse on normal completion
fifo_level  output  clog2(DEPTH)+1  entries queued, excluding the executing segment

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE, FIFO empty, remaining=0; cnt_en=0, cnt_ud=0, busy=0, done=0, fifo_level=0. Holds until reset=1; first active edge after release.
- FIFO: DEPTH entries of {dir, hold, len}. seg_ready = (fifo_level < DEPTH), combinational from level only. Push allowed in any state. A push and a pop in the same cycle leave the level unchanged. seg_valid while full is ignored (no push, no error).
- FSM states: IDLE, RUN, DONE.
- IDLE: cnt_en=0, busy=0. start && fifo_level>0 -> pop head into current regs, remaining=len (0 -> 2^LEN_W), go RUN. start with an empty FIFO is ignored.
- RUN: registered outputs cnt_en=~cur_hold, cnt_ud=cur_dir, busy=1. The first RUN cycle (edge after start) already drives the first segment. remaining decrements each cycle.
  - remaining==1 and FIFO non-empty: pop next segment on that edge. The next cycle drives the new segment with no gap.
  - remaining==1 and FIFO empty: go DONE.
  - start in RUN is ignored.
- Segment of length L yields exactly L consecutive cycles of its cnt_en/cnt_ud values.
- DONE: cnt_en=0, cnt_ud holds last value, busy=0, done=1 for exactly one cycle, then IDLE. Segments pushed after the last pop but before DONE stay queued for the next start.
- abort (any state, synchronous): next edge FIFO cleared, FSM=IDLE, cnt_en=0, cnt_ud=0, busy=0. No done pulse. Abort has priority over start, push and pop in the same cycle; a coinciding seg_valid is dropped.
- Late push: while RUN with FIFO empty, a segment pushed in a cycle where remaining>1 is executed seamlessly. If pushed in the same cycle as the remaining==1 decision, it is not executed; FSM goes DONE and the segment stays queued.
- All outputs are registered except seg_ready.

Test Plan:
- Reset mid-RUN: drop reset while cnt_en=1 -> all outputs 0 immediately without waiting for a clock edge; FIFO empty after release; start is ignored until a new push.
- Single segment {dir=1, hold=0, len=5}, then start -> cnt_en=1/cnt_ud=1 for exactly 5 cycles beginning at the edge after start; done pulses once on the following cycle; busy high for exactly 5 cycles.
- Back-to-back {0,0,3},{1,1,2},{1,0,4} -> en/ud trace: en=1 ud=0 ×3, en=0 ud=1 ×2, en=1 ud=1 ×4, with no idle cycles between segments; then one done pulse.
- Fill DEPTH=4 segments -> seg_ready=0 and fifo_level=4; a 5th seg_valid is dropped. After start and the first pop, fifo_level=3 and seg_ready=1.
- len=0 with LEN_W=8 -> cnt_en high for exactly 256 cycles.
- abort asserted on the 3rd cycle of a 10-cycle segment with 2 queued segments -> next cycle cnt_en=0, busy=0, fifo_level=0, done never pulses; a following start with an empty FIFO has no effect.
